// File: rtl/clint_arb.sv
// clint_arb: machine-mode interrupt controller for NUM_IRQ peripheral lines.
// It arbitrates ecall/ebreak, masked peripheral interrupts and mret. It then
// sequences the mepc/mstatus/mcause CSR writes, redirects EX to the trap
// vector (direct or vectored) and stalls the pipeline while it does so.
//
// Ports:
//   clk, rst            core clock, synchronous active-low reset
//   irq_i, irq_en_i     peripheral interrupt lines and per-line enables
//   id_pc, id_inst      PC and instruction currently in ID
//   ex_jump_flag/addr   EX redirect in progress and its target
//   csr_mtvec/mepc/mstatus  current CSR images
//   clint_hold_flag     pipeline stall request (combinational)
//   csr_we/waddr/wdata  registered CSR write port
//   int_assert/int_addr one-cycle redirect pulse and target
//   irq_ack_o           one-hot acknowledge of the accepted line
//   irq_pending_o       current pending vector
module clint_arb #(
  parameter int NUM_IRQ       = 8,
  parameter int XLEN          = 32,
  parameter bit EDGE_MODE     = 1'b1,
  parameter int IRQ_CODE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [31:0]        id_inst,
  input  logic               ex_jump_flag,
  input  logic [XLEN-1:0]    ex_jump_addr,
  input  logic [XLEN-1:0]    csr_mtvec,
  input  logic [XLEN-1:0]    csr_mepc,
  input  logic [XLEN-1:0]    csr_mstatus,
  output logic               clint_hold_flag,
  output logic               csr_we,
  output logic [11:0]        csr_waddr,
  output logic [XLEN-1:0]    csr_wdata,
  output logic               int_assert,
  output logic [XLEN-1:0]    int_addr,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic [NUM_IRQ-1:0] irq_pending_o
);

  localparam int          IDX_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef enum logic [2:0] {
    S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_TRAP, S_MRET
  } state_t;

  state_t state, state_next;

  logic [NUM_IRQ-1:0] pend, cand, ack;
  logic [IDX_W-1:0]   idx;
  logic               found;
  logic               is_ecall, is_ebreak, is_mret, async_req;
  logic               take_sync, take_async, take_mret;
  logic [XLEN-1:0]    code, base, acc_pc, acc_cause, acc_target;
  logic [XLEN-1:0]    pc_p0, cause_p0, target_p0;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  function automatic logic [XLEN-1:0] mstatus_trap(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1.
  function automatic logic [XLEN-1:0] mstatus_mret(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r    = s;
    r[3] = s[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Pending capture. The registered copy of irq_i keeps loading during reset
  // so that lines already high at reset release do not look like new edges.
  generate
    if (EDGE_MODE) begin : g_edge
      logic [NUM_IRQ-1:0] irq_p0, pend_p0;
      always_ff @(posedge clk) begin
        irq_p0 <= irq_i;
        if (!rst) pend_p0 <= '0;
        else      pend_p0 <= (pend_p0 & ~ack) | (irq_i & ~irq_p0);
      end
      assign pend = pend_p0;
    end else begin : g_level
      assign pend = rst ? irq_i : '0;
    end
  endgenerate

  assign cand      = pend & irq_en_i;
  assign async_req = (|cand) && csr_mstatus[3];
  assign is_ecall  = (id_inst == INST_ECALL);
  assign is_ebreak = (id_inst == INST_EBREAK);
  assign is_mret   = (id_inst == INST_MRET);

  // Priority: synchronous exception > interrupt > mret.
  assign take_sync  = rst && (is_ecall || is_ebreak);
  assign take_async = rst && async_req && !take_sync;
  assign take_mret  = rst && is_mret && !async_req && !take_sync;

  // Lowest enabled pending line wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cand[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  assign code       = XLEN'(IRQ_CODE_BASE) + XLEN'(idx);
  assign base       = {csr_mtvec[XLEN-1:2], 2'b00};
  assign acc_target = (take_async && csr_mtvec[1:0] == 2'b01) ? base + (code << 2) : base;
  assign acc_cause  = take_sync ? (is_ecall ? XLEN'(11) : XLEN'(3))
                                : {1'b1, code[XLEN-2:0]};
  // A synchronous trap re-executes the faulting instruction, so with EX
  // redirecting it points one instruction before the redirect target.
  assign acc_pc     = ex_jump_flag ? (take_sync ? ex_jump_addr - XLEN'(4) : ex_jump_addr)
                                   : id_pc;

  always_comb begin
    state_next      = state;
    clint_hold_flag = 1'b0;
    ack             = '0;
    unique case (state)
      S_IDLE: begin
        clint_hold_flag = take_sync || take_async || take_mret;
        if (take_async) ack = NUM_IRQ'(1) << idx;
        if (take_sync || take_async) state_next = S_MEPC;
        else if (take_mret)          state_next = S_MRET;
      end
      S_MEPC:    begin clint_hold_flag = 1'b1; state_next = S_MSTATUS; end
      S_MSTATUS: begin clint_hold_flag = 1'b1; state_next = S_MCAUSE;  end
      S_MCAUSE:  begin clint_hold_flag = 1'b1; state_next = S_TRAP;    end
      S_TRAP:    begin clint_hold_flag = 1'b1; state_next = S_IDLE;    end
      S_MRET:    begin clint_hold_flag = 1'b1; state_next = S_IDLE;    end
      default:   state_next = S_IDLE;
    endcase
  end

  assign irq_ack_o     = ack;
  assign irq_pending_o = pend;

  // Stage p0: acceptance capture and registered CSR/redirect outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc_p0      <= '0;
      cause_p0   <= '0;
      target_p0  <= '0;
      csr_we     <= 1'b0;
      csr_waddr  <= '0;
      csr_wdata  <= '0;
      int_assert <= 1'b0;
      int_addr   <= '0;
    end else begin
      state      <= state_next;
      csr_we     <= 1'b0;
      csr_waddr  <= '0;
      csr_wdata  <= '0;
      int_assert <= 1'b0;
      int_addr   <= '0;
      if (state == S_IDLE && (take_sync || take_async || take_mret)) begin
        pc_p0     <= acc_pc;
        cause_p0  <= acc_cause;
        target_p0 <= acc_target;
      end
      unique case (state)
        S_MEPC: begin
          csr_we    <= 1'b1;
          csr_waddr <= 12'h341;
          csr_wdata <= pc_p0;
        end
        S_MSTATUS: begin
          csr_we    <= 1'b1;
          csr_waddr <= 12'h300;
          csr_wdata <= mstatus_trap(csr_mstatus);
        end
        S_MCAUSE: begin
          csr_we    <= 1'b1;
          csr_waddr <= 12'h342;
          csr_wdata <= cause_p0;
        end
        S_TRAP: begin
          int_assert <= 1'b1;
          int_addr   <= target_p0;
        end
        S_MRET: begin
          csr_we     <= 1'b1;
          csr_waddr  <= 12'h300;
          csr_wdata  <= mstatus_mret(csr_mstatus);
          int_assert <= 1'b1;
          int_addr   <= csr_mepc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_arb.sv
// tb_clint_arb: table-driven and hand-sequenced bench for clint_arb with
// default parameters (8 lines, XLEN 32, edge mode, code base 16). Expected CSR
// writes and redirect targets are queued when stimulus is applied and popped
// by a monitor whenever the DUT raises csr_we or int_assert.
module tb_clint_arb;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq, irq_en;
  logic [31:0] id_pc, id_inst, ex_jump_addr, csr_mtvec, csr_mepc, csr_mstatus;
  logic        ex_jump_flag;
  logic        hold, csr_we, int_assert;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, int_addr;
  logic [7:0]  irq_ack, irq_pending;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clint_arb dut (
    .clk(clk), .rst(rst), .irq_i(irq), .irq_en_i(irq_en),
    .id_pc(id_pc), .id_inst(id_inst),
    .ex_jump_flag(ex_jump_flag), .ex_jump_addr(ex_jump_addr),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
    .clint_hold_flag(hold), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .int_assert(int_assert), .int_addr(int_addr),
    .irq_ack_o(irq_ack), .irq_pending_o(irq_pending)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] inst, pc;
    logic [7:0]  pulse, en;
    logic [31:0] mstatus, mtvec, mepc;
    logic        jump;
    logic [31:0] jaddr;
    logic        mret;
    logic [31:0] exp_mepc, exp_mstatus, exp_mcause, exp_addr;
    logic [7:0]  exp_ack;
    int          exp_hold;
  } vec_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  wr_t         mon_w;
  logic [31:0] mon_a;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write/redirect must match the head of its queue.
  always @(negedge clk) begin
    if (csr_we) begin
      if (wr_q.size() == 0) check("csr_we_unexpected", 32'(csr_we), 32'd0);
      else begin
        mon_w = wr_q.pop_front();
        check("csr_waddr", 32'(csr_waddr), 32'(mon_w.addr));
        check("csr_wdata", csr_wdata, mon_w.data);
      end
    end else if (csr_waddr != 12'd0 || csr_wdata != 32'd0) begin
      check("csr_idle_data", csr_wdata | 32'(csr_waddr), 32'd0);
    end
    if (int_assert) begin
      if (rd_q.size() == 0) check("int_assert_unexpected", 32'(int_assert), 32'd0);
      else begin
        mon_a = rd_q.pop_front();
        check("int_addr", int_addr, mon_a);
      end
    end else if (int_addr != 32'd0) begin
      check("int_addr_idle", int_addr, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] p);
    irq = p;
    step();
    irq = 8'h00;
  endtask

  task automatic push_trap(input logic [31:0] pc, input logic [31:0] ms,
                           input logic [31:0] cause, input logic [31:0] tgt);
    wr_q.push_back({12'h341, pc});
    wr_q.push_back({12'h300, ms});
    wr_q.push_back({12'h342, cause});
    rd_q.push_back(tgt);
  endtask

  task automatic drain(input string tag);
    check({tag, "_wr_drain"}, 32'(wr_q.size()), 32'd0);
    check({tag, "_rd_drain"}, 32'(rd_q.size()), 32'd0);
    check({tag, "_pend_clear"}, 32'(irq_pending), 32'd0);
    wr_q.delete();
    rd_q.delete();
  endtask

  task automatic setup(input logic [31:0] pc, input logic [7:0] en, input logic [31:0] ms,
                       input logic [31:0] mtvec, input logic [31:0] mepc,
                       input logic jump, input logic [31:0] jaddr);
    id_inst      = NOP;
    id_pc        = pc;
    irq_en       = en;
    csr_mstatus  = ms;
    csr_mtvec    = mtvec;
    csr_mepc     = mepc;
    ex_jump_flag = jump;
    ex_jump_addr = jaddr;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    string tag;
    int    hold_cnt;
    tag = $sformatf("v%0d", n);
    setup(v.pc, v.en, v.mstatus, v.mtvec, v.mepc, v.jump, v.jaddr);
    if (v.mret) begin
      wr_q.push_back({12'h300, v.exp_mstatus});
      rd_q.push_back(v.exp_addr);
    end else begin
      push_trap(v.exp_mepc, v.exp_mstatus, v.exp_mcause, v.exp_addr);
    end
    if (v.pulse != 8'h00) pulse(v.pulse);
    id_inst  = v.inst;
    hold_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) check({tag, "_ack"}, 32'(irq_ack), 32'(v.exp_ack));
      if (hold) hold_cnt++;
      step();
      id_inst = NOP;
    end
    check({tag, "_hold_cycles"}, 32'(hold_cnt), 32'(v.exp_hold));
    drain(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int hc;
    //            inst    pc        pulse  en     mstatus   mtvec         mepc      j     jaddr    mret  mepc      mstatus   mcause        addr          ack    hold
    vecs[0] = '{ECALL,  32'h100, 8'h00, 8'h00, 32'h8,    32'h200,      32'h0,    1'b0, 32'h0,   1'b0, 32'h100, 32'h1880, 32'd11,        32'h200,      8'h00, 5};
    vecs[1] = '{EBREAK, 32'h180, 8'h00, 8'h00, 32'h0,    32'h201,      32'h0,    1'b0, 32'h0,   1'b0, 32'h180, 32'h1800, 32'd3,         32'h200,      8'h00, 5};
    vecs[2] = '{NOP,    32'h400, 8'h20, 8'h20, 32'h8,    32'h201,      32'h0,    1'b0, 32'h0,   1'b0, 32'h400, 32'h1880, 32'h8000_0015, 32'h254,      8'h20, 5};
    vecs[3] = '{NOP,    32'h500, 8'h01, 8'h01, 32'h88,   32'h300,      32'h0,    1'b0, 32'h0,   1'b0, 32'h500, 32'h1880, 32'h8000_0010, 32'h300,      8'h01, 5};
    vecs[4] = '{NOP,    32'h480, 8'h80, 8'h80, 32'h8,    32'h201,      32'h0,    1'b1, 32'h340, 1'b0, 32'h340, 32'h1880, 32'h8000_0017, 32'h25C,      8'h80, 5};
    vecs[5] = '{ECALL,  32'h480, 8'h00, 8'h00, 32'h8,    32'h201,      32'h0,    1'b1, 32'h340, 1'b0, 32'h33C, 32'h1880, 32'd11,        32'h200,      8'h00, 5};
    vecs[6] = '{MRET,   32'h108, 8'h00, 8'h00, 32'h1880, 32'h200,      32'h104,  1'b0, 32'h0,   1'b1, 32'h0,   32'h1888, 32'h0,         32'h104,      8'h00, 2};
    vecs[7] = '{MRET,   32'h10C, 8'h00, 8'h00, 32'h1800, 32'h200,      32'h2000, 1'b0, 32'h0,   1'b1, 32'h0,   32'h1880, 32'h0,         32'h2000,     8'h00, 2};
    vecs[8] = '{NOP,    32'h600, 8'h08, 8'h08, 32'h8,    32'hFFFF_FFF1, 32'h0,   1'b0, 32'h0,   1'b0, 32'h600, 32'h1880, 32'h8000_0013, 32'h3C,       8'h08, 5};

    // Reset with all lines high, enabled and MIE set.
    rst = 1'b0;
    irq = 8'hFF;
    setup(32'h0, 8'hFF, 32'h8, 32'h200, 32'h0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_csr_we", 32'(csr_we), 32'd0);
    check("rst_csr_waddr", 32'(csr_waddr), 32'd0);
    check("rst_csr_wdata", csr_wdata, 32'd0);
    check("rst_int_assert", 32'(int_assert), 32'd0);
    check("rst_int_addr", int_addr, 32'd0);
    check("rst_ack", 32'(irq_ack), 32'd0);
    check("rst_pending", 32'(irq_pending), 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rel_hold", 32'(hold), 32'd0);
    check("rel_pending", 32'(irq_pending), 32'd0);
    step();
    irq    = 8'h00;
    irq_en = 8'h00;
    step();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Lines 2 and 6 together: 2 first, 6 in the next IDLE window.
    setup(32'h600, 8'h44, 32'h8, 32'h201, 32'h0, 1'b0, 32'h0);
    push_trap(32'h600, 32'h1880, 32'h8000_0012, 32'h248);
    push_trap(32'h600, 32'h1880, 32'h8000_0016, 32'h258);
    pulse(8'h44);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("dual_ack_first", 32'(irq_ack), 32'h04);
        check("dual_pending", 32'(irq_pending), 32'h44);
      end
      if (c == 5) check("dual_ack_second", 32'(irq_ack), 32'h40);
      step();
    end
    drain("dual");

    // ecall coincident with an interrupt: ecall first, interrupt stays pending.
    setup(32'h700, 8'h02, 32'h8, 32'h200, 32'h0, 1'b0, 32'h0);
    push_trap(32'h700, 32'h1880, 32'd11, 32'h200);
    push_trap(32'h700, 32'h1880, 32'h8000_0011, 32'h200);
    pulse(8'h02);
    id_inst = ECALL;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("ecall_irq_ack0", 32'(irq_ack), 32'h00);
        check("ecall_irq_pend0", 32'(irq_pending), 32'h02);
      end
      if (c == 5) check("ecall_irq_ack5", 32'(irq_ack), 32'h02);
      step();
      id_inst = NOP;
    end
    drain("ecall_irq");

    // mret in ID with an interrupt pending: interrupt first, then mret.
    setup(32'h800, 8'h08, 32'h1888, 32'h200, 32'h104, 1'b0, 32'h0);
    push_trap(32'h800, 32'h1880, 32'h8000_0013, 32'h200);
    wr_q.push_back({12'h300, 32'h1888});
    rd_q.push_back(32'h104);
    pulse(8'h08);
    id_inst = MRET;
    hc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) check("mret_irq_ack", 32'(irq_ack), 32'h08);
      if (hold) hc++;
      step();
      if (c >= 5) id_inst = NOP;
    end
    check("mret_irq_hold_cycles", 32'(hc), 32'd7);
    drain("mret_irq");

    // Masked line stays pending; taken once enabled with MIE set.
    setup(32'h900, 8'h00, 32'h8, 32'h200, 32'h0, 1'b0, 32'h0);
    pulse(8'h02);
    @(negedge clk);
    check("mask_pending", 32'(irq_pending), 32'h02);
    check("mask_hold", 32'(hold), 32'd0);
    step();
    csr_mstatus = 32'h0;
    irq_en      = 8'h02;
    @(negedge clk);
    check("mie0_hold", 32'(hold), 32'd0);
    step();
    push_trap(32'h900, 32'h1880, 32'h8000_0011, 32'h200);
    csr_mstatus = 32'h8;
    @(negedge clk);
    check("unmask_hold", 32'(hold), 32'd1);
    check("unmask_ack", 32'(irq_ack), 32'h02);
    for (int c = 0; c < 8; c++) step();
    drain("unmask");

    // Reset in the MSTATUS state: mepc write lands, nothing after it.
    setup(32'hA00, 8'h00, 32'h8, 32'h200, 32'h0, 1'b0, 32'h0);
    wr_q.push_back({12'h341, 32'hA00});
    id_inst = ECALL;
    step();
    id_inst = NOP;
    step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_hold", 32'(hold), 32'd0);
    check("midrst_csr_we", 32'(csr_we), 32'd0);
    for (int c = 0; c < 8; c++) step();
    drain("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
